rom_loader: RTL and testbench

- Boot-time writer for the Hack instruction memory: fills the ROM that the program counter later reads.
- Consumes a byte stream from the serial receiver and assembles big-endian 16-bit instruction words.
- Writes the words to consecutive ROM addresses starting at 0.
- Holds the CPU in reset until a complete program image has been written, then releases it so the PC starts fetching from address 0.

---
 rtl/rom_loader_pkg.sv | 22 ++
 rtl/rom_loader_timeout.sv | 33 +++
 rtl/rom_loader.sv | 133 +++++++++++++
 tb/tb_rom_loader.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/rom_loader_pkg.sv
// Shared constants for the Hack boot loader: state encoding, word and ROM address widths.
// Also used by other serial-fed blocks that load the Hack instruction memory.
package rom_loader_pkg;

    localparam int HACK_WORD_WIDTH     = 16;
    localparam int HACK_ROM_ADDR_WIDTH = 15;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LEN_LO  = 3'd1;
    localparam logic [2:0] ST_DATA_HI = 3'd2;
    localparam logic [2:0] ST_DATA_LO = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    typedef logic [HACK_WORD_WIDTH-1:0] hack_word_t;

    // States in which an image is in flight and the inter-byte timer runs.
    function automatic logic is_receiving(input logic [2:0] state);
        return (state == ST_LEN_LO) || (state == ST_DATA_HI) || (state == ST_DATA_LO);
    endfunction

endpackage

// File: rtl/rom_loader_timeout.sv
// Loadable down-counter with clear and expiry flag, used as an inter-byte watchdog.
// Load has priority over clear; an enabled counter stops at zero and flags expiry there.
module rom_loader_timeout
    import rom_loader_pkg::*;
#(
    parameter int WIDTH = 20
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_clear,
    input  logic             i_enable,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_expired = (r_count == '0);

endmodule

// File: rtl/rom_loader.sv
// Boot-time ROM writer: assembles big-endian 16-bit words from a byte stream,
// writes them from address 0 upward and holds the CPU in reset until the image is complete.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = HACK_ROM_ADDR_WIDTH,
    parameter int TIMEOUT    = 1_000_000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [7:0]                 i_rx_data,
    input  logic                       i_rx_valid,
    output logic [ADDR_WIDTH-1:0]      o_wr_addr,
    output logic [HACK_WORD_WIDTH-1:0] o_wr_data,
    output logic                       o_wr_en,
    output logic                       o_cpu_reset,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_error
);

    localparam int              TO_WIDTH = $clog2(TIMEOUT + 1);
    localparam logic [TO_WIDTH-1:0] TO_LOAD = TO_WIDTH'(TIMEOUT - 1);
    localparam logic [31:0]     CAPACITY = 32'd1 << ADDR_WIDTH;

    logic [2:0]                 r_state;
    logic [7:0]                 r_len_hi;
    logic [7:0]                 r_data_hi;
    logic [15:0]                r_remaining;
    logic [ADDR_WIDTH:0]        r_addr_cnt;
    logic [ADDR_WIDTH-1:0]      r_wr_addr;
    hack_word_t                 r_wr_data;
    logic                       r_wr_en;

    logic [15:0]                w_len;
    logic                       w_len_too_big;
    logic                       w_receiving;
    logic                       w_expired;
    logic                       w_timeout;
    logic                       w_addr_in_range;

    assign w_len           = {r_len_hi, i_rx_data};
    assign w_len_too_big   = ({16'd0, w_len} > CAPACITY);
    assign w_receiving     = is_receiving(r_state);
    // A byte arriving on the expiry edge wins over the timeout.
    assign w_timeout       = w_receiving && w_expired && !i_rx_valid;
    // The length check keeps the extra address bit clear; this only guards against wrap.
    assign w_addr_in_range = !r_addr_cnt[ADDR_WIDTH];

    rom_loader_timeout #(
        .WIDTH(TO_WIDTH)
    ) u_timeout (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_load      (i_rx_valid),
        .i_load_value(TO_LOAD),
        .i_clear     (!w_receiving),
        .i_enable    (w_receiving),
        .o_expired   (w_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_len_hi    <= '0;
            r_data_hi   <= '0;
            r_remaining <= '0;
            r_addr_cnt  <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_en     <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (i_rx_valid) begin
                        r_len_hi   <= i_rx_data;
                        r_addr_cnt <= '0;
                        r_state    <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (i_rx_valid) begin
                        if (w_len == 16'd0) begin
                            r_state <= ST_DONE;
                        end else if (w_len_too_big) begin
                            r_state <= ST_ERR;
                        end else begin
                            r_remaining <= w_len;
                            r_state     <= ST_DATA_HI;
                        end
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end
                end
                ST_DATA_HI: begin
                    if (i_rx_valid) begin
                        r_data_hi <= i_rx_data;
                        r_state   <= ST_DATA_LO;
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end
                end
                ST_DATA_LO: begin
                    if (i_rx_valid) begin
                        if (w_addr_in_range) begin
                            r_wr_data <= {r_data_hi, i_rx_data};
                            r_wr_addr <= r_addr_cnt[ADDR_WIDTH-1:0];
                            r_wr_en   <= 1'b1;
                        end
                        r_addr_cnt  <= r_addr_cnt + 1'b1;
                        r_remaining <= r_remaining - 16'd1;
                        r_state     <= (r_remaining > 16'd1) ? ST_DATA_HI : ST_DONE;
                    end else if (w_timeout) begin
                        r_state <= ST_ERR;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_wr_addr   = r_wr_addr;
    assign o_wr_data   = r_wr_data;
    assign o_wr_en     = r_wr_en;
    assign o_cpu_reset = (r_state != ST_DONE);
    assign o_busy      = w_receiving;
    assign o_done      = (r_state == ST_DONE);
    assign o_error     = (r_state == ST_ERR);

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader: directed byte streams push expected ROM writes,
// a monitor pops and compares on every write strobe; status is checked at fixed cycles.
module tb_rom_loader;

    localparam int AW = 15;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          wr_en;
    logic          cpu_reset;
    logic          busy;
    logic          done;
    logic          error;

    int  n_vectors = 0;
    int  n_miscompares = 0;
    wr_t exp_q[$];

    rom_loader #(.ADDR_WIDTH(AW), .TIMEOUT(16)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_rx_data  (rx_data),
        .i_rx_valid (rx_valid),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_wr_en    (wr_en),
        .o_cpu_reset(cpu_reset),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vectors++;
        if (act !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Status vector is {cpu_reset, busy, done, error}.
    task automatic check_status(input string name, input logic [3:0] exp);
        check(name, {28'd0, cpu_reset, busy, done, error}, {28'd0, exp});
    endtask

    // Called aligned to a falling edge; returns at the next falling edge.
    task automatic drive(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                n_vectors++;
                n_miscompares++;
                $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", wr_addr, wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write", {1'b0, wr_addr, wr_data}, {1'b0, e.addr, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and idle
        repeat (2) @(negedge clk);
        check_status("reset_status", 4'b1000);
        check("reset_wr", {15'd0, wr_en, wr_addr, wr_data}, 32'd0);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check_status("idle_status", 4'b1000);

        // Two-word image, back to back
        expect_wr(15'd0, 16'h1234);
        expect_wr(15'd1, 16'hABCD);
        rx_valid = 1'b1;
        drive(8'h00);
        check_status("img2_busy", 4'b1100);
        rx_valid = 1'b1;
        drive(8'h02); rx_valid = 1'b1;
        drive(8'h12); rx_valid = 1'b1;
        drive(8'h34); rx_valid = 1'b1;
        drive(8'hAB); rx_valid = 1'b1;
        drive(8'hCD);
        check_status("img2_done", 4'b0010);
        repeat (3) @(negedge clk);
        check("img2_queue_empty", exp_q.size(), 32'd0);

        // Zero-length image, then a one-word reload from DONE
        drive(8'h00);
        drive(8'h00);
        check_status("len0_done", 4'b0010);
        repeat (3) @(negedge clk);
        expect_wr(15'd0, 16'hFFFF);
        drive(8'h00);
        check_status("reload_first_byte", 4'b1100);
        drive(8'h01);
        drive(8'hFF);
        drive(8'hFF);
        check_status("reload_done", 4'b0010);
        repeat (3) @(negedge clk);
        check("reload_queue_empty", exp_q.size(), 32'd0);

        // Timeout after one of three words
        expect_wr(15'd0, 16'h1122);
        drive(8'h00);
        drive(8'h03);
        drive(8'h11);
        drive(8'h22);
        repeat (15) @(negedge clk);
        check_status("timeout_cycle15", 4'b1100);
        @(negedge clk);
        check_status("timeout_cycle16", 4'b1001);
        check("timeout_queue_empty", exp_q.size(), 32'd0);

        // Oversized length 0x8001
        drive(8'h80);
        check_status("oversize_first_byte", 4'b1100);
        drive(8'h01);
        check_status("oversize_err", 4'b1001);
        repeat (3) @(negedge clk);

        // Asynchronous reset mid-image, then a clean one-word image
        drive(8'h00);
        drive(8'h02);
        drive(8'hAA);
        #2;
        reset = 1'b1;
        #1;
        check_status("async_reset_status", 4'b1000);
        check("async_reset_wr", {15'd0, wr_en, wr_addr, wr_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_wr(15'd0, 16'h5566);
        drive(8'h00);
        drive(8'h01);
        drive(8'h55);
        drive(8'h66);
        check_status("post_reset_done", 4'b0010);
        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
